div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, operand width; result width is 2*DATA_W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned; sampled at start acceptance.
REQ-005 opdata1_i  input  DATA_W  dividend; sampled at start acceptance.
REQ-006 opdata2_i  input  DATA_W  divisor; sampled at start acceptance.
REQ-007 start_i  input  1  request from EX stage; level, held high until ready_o seen.
REQ-008 annul_i  input  1  cancel; aborts any in-flight divide.
REQ-009 result_o  output  2*DATA_W  {remainder, quotient}; valid only while ready_o=1.
REQ-010 ready_o  output  1  result valid; registered.
REQ-011 busy_o  output  1  high in any state other than FREE; EX stage uses it to stall the pipeline.

Function
REQ-012 The block SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-013 The FREE state SHALL accept a request on a rising edge with start_i=1 and annul_i=0.
- On acceptance with divisor=0, the next state SHALL be BYZERO.
- On acceptance with a nonzero divisor, the next state SHALL be ON, with the operands latched and the iteration counter cleared to 0.
REQ-014 On acceptance with signed_div_i=1, the block SHALL latch the magnitude of each negative operand (its two's complement) and record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
REQ-015 In the ON state, each edge SHALL perform one restoring-division step: shift the partial remainder left 1 and bring in the next dividend bit, MSB first; subtract the divisor if the result is nonnegative and shift in quotient bit 1, else shift in 0; increment the counter.
REQ-016 When the counter reaches DATA_W, the next edge SHALL apply sign correction (negate the quotient and/or remainder per REQ-014 when signed), register result_o, set ready_o=1, and enter END.
REQ-017 Latency SHALL be fixed: with acceptance edge E0, ready_o rises after edge E(DATA_W+1), i.e. E33 for DATA_W=32, independent of operand values.
REQ-018 From BYZERO, the next edge SHALL enter END with result_o=0 and ready_o=1, i.e. ready_o rises after E1.
REQ-019 In END, result_o and ready_o SHALL hold while start_i=1.
- On the first edge with start_i=0, the block SHALL return to FREE with result_o=0 and ready_o=0.
REQ-020 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge, with ready_o=0, result_o=0 and the counter cleared.
- annul_i in END SHALL have the same effect.
- annul_i in FREE SHALL block acceptance.
REQ-021 start_i and operand changes after acceptance SHALL be ignored until the block returns to FREE.
REQ-022 A signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0, with no trap or flag.
REQ-023 Unsigned division SHALL treat all DATA_W bits as magnitude.

Reset
REQ-024 With rst=0, the block SHALL immediately (asynchronously) force state=FREE, counter=0, result_o=0, ready_o=0 and busy_o=0.
REQ-025 Reset asserted mid-operation SHALL discard all partial results; after rst rises, no ready_o SHALL occur without a new acceptance.

Verification
REQ-026 Unsigned 100/7, start held -> ready_o rises after E33; result_o = {0x00000002, 0x0000000E}; busy_o high E0..end.
REQ-027 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF at E33.
REQ-028 Divisor 0 (either signedness) -> BYZERO; ready_o after E1; result_o = 0; drop start_i -> FREE, ready_o=0 next edge.
REQ-029 annul_i pulsed at E10 of a divide -> FREE at E11; ready_o stays 0 for 40 further cycles with start_i low; a new 9/3 then returns {0, 3} at its own E33.
REQ-030 rst pulsed low mid-ON (between edges) -> ready_o=0 and busy_o=0 immediately; signed 0x80000000/0xFFFFFFFF after release -> {0, 0x80000000}.
REQ-031 start_i held 5 cycles in END with operands changing -> result_o unchanged; no second divide starts until start_i is deasserted for at least one edge.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Handshake and operand bus between the EX stage (master) and the divider (slave).
interface div_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for the EX stage: fixed DATA_W+1 cycle latency,
// signed/unsigned, divide-by-zero short path, annul and level start handshake.
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    div_ctrl_if.slave  div_if
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]          state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [DATA_W-1:0]   divisor_q,  divisor_d;
    logic [DATA_W-1:0]   dq_q,       dq_d;
    logic [DATA_W-1:0]   rem_q,      rem_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q,  neg_rem_d;
    logic [2*DATA_W-1:0] result_q,   result_d;
    logic                ready_q,    ready_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_mag, op2_mag;
    logic [DATA_W:0]     partial, trial;
    logic                qbit;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    assign op1_neg = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
    assign op2_neg = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
    assign op1_mag = op1_neg ? -div_if.opdata1_i : div_if.opdata1_i;
    assign op2_mag = op2_neg ? -div_if.opdata2_i : div_if.opdata2_i;

    // dq_q starts as the dividend and fills with quotient bits from the LSB as
    // dividend bits leave at the MSB, so after DATA_W steps it holds the quotient.
    assign partial  = {rem_q, dq_q[DATA_W-1]};
    assign trial    = partial - {1'b0, divisor_q};
    assign qbit     = ~trial[DATA_W];
    assign quot_fix = neg_quot_q ? -dq_q  : dq_q;
    assign rem_fix  = neg_rem_q  ? -rem_q : rem_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_FREE: begin
                if (div_if.start_i && !div_if.annul_i) begin
                    if (div_if.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = '0;
                        divisor_d  = op2_mag;
                        dq_d       = op1_mag;
                        rem_d      = '0;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                    end
                end
            end
            S_BYZERO: begin
                if (div_if.annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (div_if.annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d  = S_END;
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                end else begin
                    rem_d = qbit ? trial[DATA_W-1:0] : partial[DATA_W-1:0];
                    dq_d  = {dq_q[DATA_W-2:0], qbit};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_END: begin
                if (div_if.annul_i || !div_if.start_i) begin
                    state_d  = S_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = S_FREE;
                cnt_d    = '0;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FREE;
            cnt_q      <= '0;
            divisor_q  <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign div_if.result_o = result_q;
    assign div_if.ready_o  = ready_q;
    assign div_if.busy_o   = (state_q != S_FREE);
endmodule
